auto_bp_collector: RTL and testbench

Frame-level collector for the bad-pixel coordinate stream produced by the DPC detector. It sits downstream of the detector's `auto_bp_valid/x/y` and `frame_detection_done` outputs. It captures every flagged coordinate of one frame into a ping-pong table. At frame end it publishes that table to the host-side read port while the next frame is captured into the other bank.

---
 rtl/auto_bp_collector.sv | 171 +++++++++++++++++
 tb/tb_auto_bp_collector.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/auto_bp_collector.sv
// Purpose: collects one frame of bad-pixel coordinates into a ping-pong table and publishes it at frame end.
// Latency: entries are stored at the sampling edge; the list is published at the frame_done edge; reads take 1 cycle.
// Backpressure: none. bp_valid is always accepted in CAPTURE, and entries past the table size are dropped and flagged.
module auto_bp_collector #(
  parameter int CNT_WIDTH   = 10,
  parameter int AUTO_BP_NUM = 256,
  parameter int AUTO_BP_BIT = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   enable,
  input  logic                   frame_start,
  input  logic                   bp_valid,
  input  logic [CNT_WIDTH-1:0]   bp_x,
  input  logic [CNT_WIDTH-1:0]   bp_y,
  input  logic                   frame_done,
  input  logic                   rd_en,
  input  logic [AUTO_BP_BIT-1:0] rd_addr,
  output logic [31:0]            rd_data,
  output logic                   rd_valid,
  output logic [AUTO_BP_BIT:0]   list_count,
  output logic                   list_overflow,
  output logic                   list_ready,
  output logic [7:0]             list_seq,
  output logic                   busy
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPTURE  = 2'd2
  } state_t;

  localparam logic [AUTO_BP_BIT:0] LP_NUM = (AUTO_BP_BIT+1)'(AUTO_BP_NUM);
  localparam logic [AUTO_BP_BIT:0] LP_ONE = {{AUTO_BP_BIT{1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [AUTO_BP_BIT:0]   r_wp;
  logic                   r_ovf;
  logic                   r_wsel;
  logic [AUTO_BP_BIT:0]   r_list_count;
  logic                   r_list_overflow;
  logic                   r_list_ready;
  logic [7:0]             r_list_seq;
  logic                   r_rd_valid;
  logic                   r_rd_hit;
  logic [31:0]            r_ram_q;
  logic [31:0]            r_bank0 [AUTO_BP_NUM];
  logic [31:0]            r_bank1 [AUTO_BP_NUM];

  logic                   w_busy;
  logic                   w_publish;
  logic                   w_start_cap;
  logic                   w_wr;
  logic                   w_drop;
  logic                   w_full;
  logic [AUTO_BP_BIT:0]   w_wp_fin;
  logic                   w_ovf_fin;
  logic [31:0]            w_wr_dat;

  assign w_full    = (r_wp == LP_NUM);
  assign w_wp_fin  = w_wr ? (r_wp + LP_ONE) : r_wp;
  assign w_ovf_fin = r_ovf | w_drop;
  assign w_wr_dat  = {16'(bp_y), 16'(bp_x)};

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: dropping enable always wins; a SOF inside a capture restarts it.
  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     w_state_nxt = ST_WAIT_SOF;
        ST_WAIT_SOF: if (frame_start) w_state_nxt = ST_CAPTURE;
        ST_CAPTURE: begin
          if (frame_start)     w_state_nxt = ST_CAPTURE;
          else if (frame_done) w_state_nxt = ST_WAIT_SOF;
        end
        default:     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: publish happens on frame_done even if enable drops in the same cycle.
  always_comb begin
    w_busy    = 1'b0;
    w_publish = 1'b0;
    w_wr      = 1'b0;
    w_drop    = 1'b0;
    if (r_state == ST_CAPTURE) begin
      w_busy    = 1'b1;
      w_publish = frame_done;
      w_wr      = bp_valid & ~w_full;
      w_drop    = bp_valid & w_full;
    end
    w_start_cap = (w_state_nxt == ST_CAPTURE) && ((r_state != ST_CAPTURE) || frame_start);
  end

  // Capture pointer, overflow flag and published list bookkeeping.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_wp            <= '0;
      r_ovf           <= 1'b0;
      r_wsel          <= 1'b0;
      r_list_count    <= '0;
      r_list_overflow <= 1'b0;
      r_list_ready    <= 1'b0;
      r_list_seq      <= 8'd0;
    end else begin
      r_list_ready <= w_publish;
      if (w_publish) begin
        r_list_count    <= w_wp_fin;
        r_list_overflow <= w_ovf_fin;
        r_wsel          <= ~r_wsel;
        r_list_seq      <= r_list_seq + 8'd1;
      end
      if (w_start_cap) begin
        r_wp  <= '0;
        r_ovf <= 1'b0;
      end else begin
        r_wp  <= w_wp_fin;
        r_ovf <= w_ovf_fin;
      end
    end
  end

  // Table write into the bank currently being filled (never the read bank).
  always_ff @(posedge aclk) begin
    if (w_wr) begin
      if (r_wsel) r_bank1[r_wp[AUTO_BP_BIT-1:0]] <= w_wr_dat;
      else        r_bank0[r_wp[AUTO_BP_BIT-1:0]] <= w_wr_dat;
    end
  end

  // Synchronous RAM read from the published bank.
  always_ff @(posedge aclk) begin
    if (rd_en) begin
      r_ram_q <= r_wsel ? r_bank0[rd_addr] : r_bank1[rd_addr];
    end
  end

  // Read strobe and in-range gate; out-of-list and pre-publish reads return zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rd_valid <= 1'b0;
      r_rd_hit   <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      r_rd_hit   <= rd_en && ({1'b0, rd_addr} < r_list_count);
    end
  end

  assign rd_data       = r_rd_hit ? r_ram_q : 32'd0;
  assign rd_valid      = r_rd_valid;
  assign list_count    = r_list_count;
  assign list_overflow = r_list_overflow;
  assign list_ready    = r_list_ready;
  assign list_seq      = r_list_seq;
  assign busy          = w_busy;

endmodule

// File: tb/tb_auto_bp_collector.sv
// Bench for auto_bp_collector: directed scenarios plus randomized frames against a queue-based model.
module tb_auto_bp_collector;
  localparam int NUM = 256;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic        frame_start = 1'b0;
  logic        bp_valid = 1'b0;
  logic [9:0]  bp_x = '0;
  logic [9:0]  bp_y = '0;
  logic        frame_done = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [8:0]  list_count;
  logic        list_overflow;
  logic        list_ready;
  logic [7:0]  list_seq;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: frame-level view with queues.
  bit          m_arm, m_cap, m_cur_ovf, m_pub_ovf;
  logic [31:0] m_cur[$];
  logic [31:0] m_pub[$];
  int          m_seq;
  logic [31:0] e_rd_data;
  logic        e_rd_valid, e_ready;

  auto_bp_collector #(.CNT_WIDTH(10), .AUTO_BP_NUM(NUM), .AUTO_BP_BIT(8)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .frame_start(frame_start),
    .bp_valid(bp_valid), .bp_x(bp_x), .bp_y(bp_y), .frame_done(frame_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .list_count(list_count), .list_overflow(list_overflow), .list_ready(list_ready),
    .list_seq(list_seq), .busy(busy)
  );

  always #5 aclk = ~aclk;

  task automatic m_reset;
    m_arm = 0; m_cap = 0; m_cur_ovf = 0; m_pub_ovf = 0; m_seq = 0;
    m_cur.delete(); m_pub.delete();
  endtask

  // Advance one clock: update the model from the inputs presented, then clear pulse inputs.
  task automatic cyc;
    e_rd_valid = rd_en;
    e_rd_data  = 32'd0;
    if (rd_en && int'(rd_addr) < m_pub.size()) e_rd_data = m_pub[rd_addr];
    e_ready = 0;
    if (m_cap) begin
      if (bp_valid) begin
        if (m_cur.size() < NUM) m_cur.push_back({6'd0, bp_y, 6'd0, bp_x});
        else m_cur_ovf = 1;
      end
      if (frame_done) begin
        m_pub = m_cur; m_pub_ovf = m_cur_ovf; m_seq = (m_seq + 1) % 256; e_ready = 1;
      end
      if (!enable) begin m_cap = 0; m_arm = 0; end
      else if (frame_start) begin m_cur.delete(); m_cur_ovf = 0; end
      else if (frame_done) begin m_cap = 0; m_arm = 1; end
    end else if (m_arm) begin
      if (!enable) m_arm = 0;
      else if (frame_start) begin m_arm = 0; m_cap = 1; m_cur.delete(); m_cur_ovf = 0; end
    end else if (enable) begin
      m_arm = 1;
    end
    @(posedge aclk); #1;
    frame_start = 0; frame_done = 0; bp_valid = 0; rd_en = 0;
  endtask

  task automatic px(input int x, input int y);
    bp_valid = 1; bp_x = 10'(x); bp_y = 10'(y);
    cyc();
  endtask

  task automatic rd(input int a);
    rd_en = 1; rd_addr = 8'(a);
    cyc();
  endtask

  task automatic test_reset;
    aresetn = 0; m_reset();
    repeat (2) @(posedge aclk);
    #1;
    n_chk++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    n_chk++; if (list_count !== 9'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", list_count); end
    n_chk++; if (list_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b exp 0", list_overflow); end
    n_chk++; if (list_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", list_ready); end
    n_chk++; if (list_seq !== 8'd0) begin n_fail++; $display("FAIL reset_seq got %0d exp 0", list_seq); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    aresetn = 1;
    rd(0);
    n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin n_fail++; $display("FAIL prepub_read got v=%b d=%h exp v=1 d=0", rd_valid, rd_data); end
  endtask

  task automatic test_basic;
    logic [31:0] exp_d [4];
    exp_d = '{32'h00000003, 32'h000A027F, 32'h01FF0005, 32'h00000000};
    enable = 1; cyc();
    frame_start = 1; cyc();
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy got %b exp 1", busy); end
    px(3, 0); px(639, 10); px(5, 511);
    frame_done = 1; cyc();
    n_chk++; if (list_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b exp 1", list_ready); end
    n_chk++; if (list_count !== 9'd3) begin n_fail++; $display("FAIL basic_count got %0d exp 3", list_count); end
    n_chk++; if (list_seq !== 8'd1) begin n_fail++; $display("FAIL basic_seq got %0d exp 1", list_seq); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %b exp 0", busy); end
    for (int i = 0; i < 4; i++) begin
      rd(i);
      n_chk++; if (list_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_pulse got %b exp 0", list_ready); end
      n_chk++; if (rd_valid !== 1'b1 || rd_data !== exp_d[i]) begin n_fail++; $display("FAIL basic_read%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, exp_d[i]); end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] sent256;
    int x, y;
    sent256 = 32'd0;
    frame_start = 1; cyc();
    for (int i = 0; i < 300; i++) begin
      x = $urandom_range(0, 1023); y = $urandom_range(0, 1023);
      if (i == 255) sent256 = {6'd0, 10'(y), 6'd0, 10'(x)};
      px(x, y);
    end
    frame_done = 1; cyc();
    n_chk++; if (list_count !== 9'd256) begin n_fail++; $display("FAIL ovf_count got %0d exp 256", list_count); end
    n_chk++; if (list_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b exp 1", list_overflow); end
    rd(255);
    n_chk++; if (rd_data !== sent256) begin n_fail++; $display("FAIL ovf_entry255 got %h exp %h", rd_data, sent256); end
    rd(17);
    n_chk++; if (rd_data !== e_rd_data) begin n_fail++; $display("FAIL ovf_entry17 got %h exp %h", rd_data, e_rd_data); end
    frame_start = 1; cyc();
    px(11, 12); px(13, 14);
    frame_done = 1; cyc();
    n_chk++; if (list_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b exp 0", list_overflow); end
    n_chk++; if (list_count !== 9'd2) begin n_fail++; $display("FAIL ovf_next_count got %0d exp 2", list_count); end
    n_chk++; if (list_seq !== 8'd3) begin n_fail++; $display("FAIL ovf_seq got %0d exp 3", list_seq); end
    rd(2);
    n_chk++; if (rd_valid !== 1'b1 || rd_data !== 32'd0) begin n_fail++; $display("FAIL ovf_gate got v=%b d=%h exp v=1 d=0", rd_valid, rd_data); end
  endtask

  task automatic test_edge;
    frame_start = 1; cyc();
    px(1, 2);
    bp_valid = 1; bp_x = 10'd7; bp_y = 10'd7; frame_done = 1; cyc();
    n_chk++; if (list_ready !== 1'b1 || list_count !== 9'd2) begin n_fail++; $display("FAIL edge_count got r=%b c=%0d exp r=1 c=2", list_ready, list_count); end
    rd(1);
    n_chk++; if (rd_data !== 32'h00070007) begin n_fail++; $display("FAIL edge_entry1 got %h exp 00070007", rd_data); end
    frame_start = 1; cyc();
    px(9, 9);
    frame_start = 1; frame_done = 1; cyc();
    n_chk++; if (list_ready !== 1'b1 || list_count !== 9'd1) begin n_fail++; $display("FAIL edge_sofeof got r=%b c=%0d exp r=1 c=1", list_ready, list_count); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL edge_busy got %b exp 1", busy); end
    px(4, 4);
    frame_done = 1; cyc();
    rd(0);
    n_chk++; if (list_count !== 9'd1 || rd_data !== 32'h00040004) begin n_fail++; $display("FAIL edge_newframe got c=%0d d=%h exp c=1 d=00040004", list_count, rd_data); end
  endtask

  task automatic test_pingpong;
    logic [31:0] a_dat [2];
    frame_start = 1; cyc();
    px($urandom_range(0, 1023), $urandom_range(0, 1023));
    px($urandom_range(0, 1023), $urandom_range(0, 1023));
    frame_done = 1; cyc();
    a_dat[0] = m_pub[0]; a_dat[1] = m_pub[1];
    frame_start = 1; cyc();
    for (int i = 0; i < 20; i++) begin
      bp_valid = (i == 0) || ($urandom_range(0, 1) == 1);
      bp_x = 10'($urandom_range(0, 1023)); bp_y = 10'($urandom_range(0, 1023));
      rd_en = 1; rd_addr = 8'(i % 2);
      cyc();
      n_chk++; if (rd_data !== a_dat[i%2] || rd_data !== e_rd_data) begin n_fail++; $display("FAIL pp_hold%0d got %h exp %h", i, rd_data, a_dat[i%2]); end
    end
    frame_done = 1; rd_en = 1; rd_addr = 8'd0; cyc();
    n_chk++; if (rd_data !== a_dat[0]) begin n_fail++; $display("FAIL pp_collide got %h exp %h", rd_data, a_dat[0]); end
    rd(0);
    n_chk++; if (rd_data !== m_pub[0]) begin n_fail++; $display("FAIL pp_newbank got %h exp %h", rd_data, m_pub[0]); end
  endtask

  task automatic test_abort;
    logic [8:0] s_cnt;
    logic [7:0] s_seq;
    s_cnt = list_count; s_seq = list_seq;
    frame_start = 1; cyc();
    for (int i = 0; i < 5; i++) px(i + 20, i + 30);
    enable = 0; cyc();
    n_chk++; if (busy !== 1'b0 || list_ready !== 1'b0) begin n_fail++; $display("FAIL abort_state got b=%b r=%b exp 0 0", busy, list_ready); end
    frame_start = 1; cyc();
    n_chk++; if (list_count !== s_cnt || list_seq !== s_seq || busy !== 1'b0) begin n_fail++; $display("FAIL abort_hold got c=%0d s=%0d b=%b exp c=%0d s=%0d b=0", list_count, list_seq, busy, s_cnt, s_seq); end
    enable = 1; cyc();
    frame_start = 1; cyc();
    frame_done = 1; cyc();
    n_chk++; if (list_ready !== 1'b1 || list_count !== 9'd0 || list_seq !== s_seq + 8'd1) begin n_fail++; $display("FAIL abort_empty got r=%b c=%0d s=%0d exp r=1 c=0 s=%0d", list_ready, list_count, list_seq, s_seq + 8'd1); end
    frame_start = 1; cyc();
    px(2, 3);
    frame_done = 1; enable = 0; cyc();
    n_chk++; if (list_ready !== 1'b1 || list_count !== 9'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_pubdrop got r=%b c=%0d b=%b exp r=1 c=1 b=0", list_ready, list_count, busy); end
    enable = 1; cyc();
  endtask

  task automatic test_random;
    int len;
    for (int f = 0; f < 6; f++) begin
      frame_start = 1; cyc();
      len = $urandom_range(5, 60);
      for (int c = 0; c < len; c++) begin
        bp_valid = ($urandom_range(0, 1) == 1);
        bp_x = 10'($urandom_range(0, 1023)); bp_y = 10'($urandom_range(0, 1023));
        rd_en = ($urandom_range(0, 2) != 0); rd_addr = 8'($urandom_range(0, 47));
        if ($urandom_range(0, 49) == 0) frame_start = 1;
        cyc();
        n_chk++; if (rd_valid !== e_rd_valid || rd_data !== e_rd_data) begin n_fail++; $display("FAIL rand_read f%0d c%0d got v=%b d=%h exp v=%b d=%h", f, c, rd_valid, rd_data, e_rd_valid, e_rd_data); end
        n_chk++; if (busy !== m_cap) begin n_fail++; $display("FAIL rand_busy f%0d c%0d got %b exp %b", f, c, busy, m_cap); end
      end
      frame_done = 1; cyc();
      n_chk++; if (list_ready !== e_ready || list_count !== 9'(m_pub.size()) || list_overflow !== m_pub_ovf || list_seq !== 8'(m_seq)) begin
        n_fail++; $display("FAIL rand_pub f%0d got r=%b c=%0d o=%b s=%0d exp r=%b c=%0d o=%b s=%0d", f, list_ready, list_count, list_overflow, list_seq, e_ready, m_pub.size(), m_pub_ovf, m_seq);
      end
    end
  endtask

  task automatic test_async_reset;
    frame_start = 1; cyc();
    px(1, 1); px(2, 2); px(3, 3);
    #3 aresetn = 0;
    #1;
    n_chk++; if (rd_data !== 32'd0 || rd_valid !== 1'b0 || list_count !== 9'd0 || list_overflow !== 1'b0 ||
                 list_ready !== 1'b0 || list_seq !== 8'd0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL areset_outputs got d=%h v=%b c=%0d o=%b r=%b s=%0d b=%b exp all 0", rd_data, rd_valid, list_count, list_overflow, list_ready, list_seq, busy);
    end
    m_reset();
    @(posedge aclk); #1;
    aresetn = 1;
    cyc();
    frame_start = 1; cyc();
    frame_done = 1; cyc();
    n_chk++; if (list_seq !== 8'd1 || list_ready !== 1'b1 || list_count !== 9'd0) begin n_fail++; $display("FAIL areset_restart got s=%0d r=%b c=%0d exp s=1 r=1 c=0", list_seq, list_ready, list_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_edge();
    test_pingpong();
    test_abort();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
